// File: rtl/riscv_lsu_if.sv
// Core/memory bus bundle for the RISC-V load/store unit.
// Signal suffixes (_i/_o) are named from the LSU's point of view.
// slave: the LSU itself; master: the environment (core pipeline + memory).
interface riscv_lsu_if;
  // core side
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        access_err_o;
  // memory side
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  mem_rd_i, mem_ready_i,
    output core_rd_o, core_stall_o, access_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );

  modport master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output mem_rd_i, mem_ready_i,
    input  core_rd_o, core_stall_o, access_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
  );
endinterface

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: aligns stores into byte lanes, extracts/extends loads.
// Latency: 3 cycles minimum (IDLE, BUSY, DONE); each cycle of mem_ready_i=0 adds a BUSY cycle.
// Backpressure: core_stall_o holds the core while a legal access starts or is in BUSY.
// Ports: clk_i, rst_ni (async active-low); bus (riscv_lsu_if.slave) carries the
//        core request/response and the word-aligned memory request/response.
module riscv_lsu (
  input  logic       clk_i,
  input  logic       rst_ni,
  riscv_lsu_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wd_q, rd_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [2:0]  size_q;

  logic        legal, start;
  logic [3:0]  be_d;
  logic [31:0] wd_d, rd_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Legality: natural alignment, and unsigned sizes exist only for loads.
  always_comb begin
    legal = 1'b0;
    case (bus.core_size_i)
      LDST_B:  legal = 1'b1;
      LDST_H:  legal = ~bus.core_addr_i[0];
      LDST_W:  legal = (bus.core_addr_i[1:0] == 2'b00);
      LDST_BU: legal = ~bus.core_we_i;
      LDST_HU: legal = ~bus.core_we_i & ~bus.core_addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  // Store lane steering; data is replicated so the enabled lanes carry it.
  always_comb begin
    be_d = 4'b0000;
    wd_d = 32'h0;
    if (bus.core_we_i) begin
      case (bus.core_size_i)
        LDST_B: begin
          be_d = 4'b0001 << bus.core_addr_i[1:0];
          wd_d = {4{bus.core_wd_i[7:0]}};
        end
        LDST_H: begin
          be_d = bus.core_addr_i[1] ? 4'b1100 : 4'b0011;
          wd_d = {2{bus.core_wd_i[15:0]}};
        end
        LDST_W: begin
          be_d = 4'b1111;
          wd_d = bus.core_wd_i;
        end
        default: ;
      endcase
    end
  end

  // Load extraction uses the registered address/size, not the live core inputs.
  assign ld_byte = bus.mem_rd_i[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = bus.mem_rd_i[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    rd_ext = bus.mem_rd_i;
    case (size_q)
      LDST_B:  rd_ext = {{24{ld_byte[7]}}, ld_byte};
      LDST_H:  rd_ext = {{16{ld_half[15]}}, ld_half};
      LDST_BU: rd_ext = {24'h0, ld_byte};
      LDST_HU: rd_ext = {16'h0, ld_half};
      default: rd_ext = bus.mem_rd_i;
    endcase
  end

  // Next state. DONE always falls back to IDLE so a held request cannot
  // re-launch before the core has seen the completed access.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: if (bus.core_req_i && legal) begin
        state_d = BUSY;
        start   = 1'b1;
      end
      BUSY: if (bus.mem_ready_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wd_q    <= 32'h0;
      size_q  <= 3'd0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q <= bus.core_addr_i;
        we_q   <= bus.core_we_i;
        be_q   <= be_d;
        wd_q   <= wd_d;
        size_q <= bus.core_size_i;
      end
      if (state_q == BUSY && bus.mem_ready_i && !we_q) rd_q <= rd_ext;
    end
  end

  assign bus.core_rd_o    = rd_q;
  assign bus.core_stall_o = (state_q == BUSY) ||
                            (state_q == IDLE && bus.core_req_i && legal);
  assign bus.access_err_o = (state_q == IDLE) && bus.core_req_i && !legal;

  assign bus.mem_req_o  = (state_q == BUSY);
  assign bus.mem_we_o   = (state_q == BUSY) && we_q;
  assign bus.mem_be_o   = (state_q == BUSY) ? be_q : 4'b0000;
  assign bus.mem_wd_o   = (state_q == BUSY) ? wd_q : 32'h0;
  assign bus.mem_addr_o = {addr_q[31:2], 2'b00};
endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: stimulus pushes expected memory requests and
// load results; a monitor checks every BUSY cycle and the DONE-cycle read data.
module tb_riscv_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_lsu_if bus();
  riscv_lsu dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  localparam logic [2:0] SB_ = 3'd0, SH_ = 3'd1, SW_ = 3'd2, SBU = 3'd4, SHU = 3'd5;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          rd_pending = 0;
  bit          mon_en = 1;
  logic [31:0] prev_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                      input logic we, input logic [31:0] rd);
    exp_t e;
    e.addr = a; e.be = be; e.wd = wd; e.we = we;
    e.rd = we ? prev_rd : rd;
    prev_rd = e.rd;
    sb.push_back(e);
  endtask

  // Monitor: looks 1 time unit after each falling edge, after the driver settles.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rd_pending) begin
        chk("core_rd", bus.core_rd_o, cur.rd);
        rd_pending = 0;
      end
      if (mon_en && bus.mem_req_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_req", {31'h0, bus.mem_req_o}, 32'h0);
        end else begin
          chk("mem_addr", bus.mem_addr_o, sb[0].addr);
          chk("mem_be", {28'h0, bus.mem_be_o}, {28'h0, sb[0].be});
          chk("mem_wd", bus.mem_wd_o, sb[0].wd);
          chk("mem_we", {31'h0, bus.mem_we_o}, {31'h0, sb[0].we});
          if (bus.mem_ready_i) begin
            cur = sb.pop_front();
            rd_pending = 1;
          end
        end
      end
    end
  end

  // One legal access; mem_ready_i rises after dly BUSY cycles. The core request
  // is dropped and scrambled in BUSY, which the DUT must ignore.
  task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int dly,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_rd);
    int stalls, busy;
    bit done;
    push(e_addr, e_be, e_wd, we, e_rd);
    @(posedge clk); #1;
    bus.core_req_i = 1'b1; bus.core_we_i = we; bus.core_size_i = sz;
    bus.core_addr_i = a; bus.core_wd_i = wd;
    bus.mem_rd_i = rdat; bus.mem_ready_i = 1'b0;
    stalls = 0; busy = 0; done = 0;
    for (int c = 0; c < dly + 10 && !done; c++) begin
      @(negedge clk);
      if (bus.core_stall_o) stalls++;
      if (bus.mem_req_o) begin
        chk("err_in_busy", {31'h0, bus.access_err_o}, 32'h0);
        bus.core_req_i = 1'b0; bus.core_we_i = ~we; bus.core_size_i = 3'd7;
        bus.core_addr_i = 32'hFFFF_FFFF;
        bus.mem_ready_i = (busy == dly);
        busy++;
      end else if (busy > 0) begin
        done = 1;
        bus.mem_ready_i = 1'b0;
      end
    end
    chk("access_done", {31'h0, done}, 32'h1);
    chk("stall_cycles", stalls, dly + 2);
    chk("busy_cycles", busy, dly + 1);
  endtask

  // Illegal request held for two cycles: error flagged, no stall, no memory access.
  task automatic bad(input logic we, input logic [2:0] sz, input logic [31:0] a, input string nm);
    @(posedge clk); #1;
    bus.core_req_i = 1'b1; bus.core_we_i = we; bus.core_size_i = sz;
    bus.core_addr_i = a; bus.core_wd_i = 32'h1234_5678;
    @(negedge clk);
    chk({nm, "_err"}, {31'h0, bus.access_err_o}, 32'h1);
    chk({nm, "_stall"}, {31'h0, bus.core_stall_o}, 32'h0);
    chk({nm, "_req"}, {31'h0, bus.mem_req_o}, 32'h0);
    @(negedge clk);
    chk({nm, "_err2"}, {31'h0, bus.access_err_o}, 32'h1);
    chk({nm, "_req2"}, {31'h0, bus.mem_req_o}, 32'h0);
    bus.core_req_i = 1'b0;
    #1;
    chk({nm, "_err_clr"}, {31'h0, bus.access_err_o}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nreq, gap;
    bit lastreq;
    bus.core_req_i = 1'b0; bus.core_we_i = 1'b0; bus.core_size_i = 3'd0;
    bus.core_addr_i = 32'h0; bus.core_wd_i = 32'h0;
    bus.mem_rd_i = 32'h0; bus.mem_ready_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'h0, bus.mem_req_o}, 32'h0);
    chk("rst_core_rd", bus.core_rd_o, 32'h0);
    chk("rst_stall", {31'h0, bus.core_stall_o}, 32'h0);
    chk("rst_be", {28'h0, bus.mem_be_o}, 32'h0);
    chk("rst_addr", bus.mem_addr_o, 32'h0);
    rst_n = 1'b1;

    // Loads
    access(0, SW_, 32'h100, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0, 32'h100, 4'b0000, 32'h0, 32'hDEAD_BEEF);
    access(0, SB_, 32'h103, 32'h0, 32'h8011_2233, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80);
    access(0, SBU, 32'h103, 32'h0, 32'h8011_2233, 0, 32'h100, 4'b0000, 32'h0, 32'h0000_0080);
    access(0, SBU, 32'h101, 32'h0, 32'h8011_2233, 1, 32'h100, 4'b0000, 32'h0, 32'h0000_0022);
    access(0, SH_, 32'h102, 32'h0, 32'h8011_2233, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_8011);
    access(0, SH_, 32'h100, 32'h0, 32'h0000_F00F, 2, 32'h100, 4'b0000, 32'h0, 32'hFFFF_F00F);
    access(0, SHU, 32'h100, 32'h0, 32'h8011_2233, 0, 32'h100, 4'b0000, 32'h0, 32'h0000_2233);

    // Stores (core_rd_o must keep the last load value)
    access(1, SH_, 32'h202, 32'h0000_ABCD, 32'h5555_5555, 3, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0);
    access(1, SH_, 32'h200, 32'hFFFF_1234, 32'h0, 0, 32'h200, 4'b0011, 32'h1234_1234, 32'h0);
    access(1, SB_, 32'h3, 32'h1234_5677, 32'h0, 1, 32'h0, 4'b1000, 32'h7777_7777, 32'h0);
    access(1, SW_, 32'h400, 32'hA5A5_0F0F, 32'h0, 0, 32'h400, 4'b1111, 32'hA5A5_0F0F, 32'h0);

    // Illegal accesses
    bad(0, SW_, 32'h101, "lw_mis");
    bad(0, SH_, 32'h103, "lh_mis");
    bad(1, SBU, 32'h100, "sbu");
    bad(0, 3'd3, 32'h100, "size3");
    bad(0, 3'd6, 32'h100, "size6");
    bad(1, SW_, 32'h102, "sw_mis");

    // Reset in the middle of BUSY abandons the access
    mon_en = 0;
    @(posedge clk); #1;
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b0; bus.core_size_i = SW_;
    bus.core_addr_i = 32'h500; bus.mem_rd_i = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_req", {31'h0, bus.mem_req_o}, 32'h1);
    bus.core_req_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_drop", {31'h0, bus.mem_req_o}, 32'h0);
    chk("rst_rd_clear", bus.core_rd_o, 32'h0);
    bus.mem_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_post_req", {31'h0, bus.mem_req_o}, 32'h0);
    chk("rst_post_rd", bus.core_rd_o, 32'h0);
    bus.mem_ready_i = 1'b0;
    prev_rd = 32'h0;
    mon_en = 1;
    access(1, SB_, 32'h1, 32'h0000_005A, 32'h0, 1, 32'h0, 4'b0010, 32'h5A5A_5A5A, 32'h0);

    // Back-to-back SW then LW with the request held through DONE
    push(32'h300, 4'b1111, 32'h1122_3344, 1, 32'h0);
    push(32'h304, 4'b0000, 32'h0, 0, 32'hCAFE_F00D);
    @(posedge clk); #1;
    bus.core_req_i = 1'b1; bus.core_we_i = 1'b1; bus.core_size_i = SW_;
    bus.core_addr_i = 32'h300; bus.core_wd_i = 32'h1122_3344;
    bus.mem_rd_i = 32'hCAFE_F00D;
    nreq = 0; gap = 0; lastreq = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.mem_req_o) begin
        if (!lastreq) nreq++;
        bus.mem_ready_i = 1'b1;
        if (nreq == 1) begin
          bus.core_we_i = 1'b0; bus.core_addr_i = 32'h304; bus.core_wd_i = 32'h9999_9999;
        end else begin
          bus.core_req_i = 1'b0;
        end
      end else begin
        bus.mem_ready_i = 1'b0;
        if (nreq == 1) gap++;
      end
      lastreq = bus.mem_req_o;
    end
    chk("b2b_nreq", nreq, 2);
    chk("b2b_gap", gap, 2);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
